serial_add_sched: RTL and testbench

Bit-serial add scheduler that shares the team's single 1-bit `full_adder_v` cell between two requesters. It accepts a WIDTH-bit add request from either port and arbitrates round-robin between them. The granted pair is fed LSB-first through the full adder, one bit per clock, with the carry held in a flop. It returns the WIDTH-bit sum, the carry-out and the requester ID on a valid/ready result channel.

---
 rtl/serial_add_sched.sv | 171 +++++++++++++++++
 tb/tb_serial_add_sched.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sched.sv
// serial_add_sched: bit-serial add scheduler sharing one full_adder_v cell
// between two requesters with round-robin arbitration.
//
// Optional feature macro: SADD_CIN_EN. When it is defined, the per-requester
// carry-in ports req0_cin/req1_cin exist. When it is undefined, the ports are
// absent and every add starts with carry 0.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   req0_valid/ready/a/b[/cin]   requester 0 operand channel
//   req1_valid/ready/a/b[/cin]   requester 1 operand channel
//   res_valid/ready              result handshake
//   res_sum[WIDTH], res_cout     WIDTH-bit sum and final carry
//   res_id                       requester that owns the result
//   busy                         operation in progress (CALC or DONE)

// 1-bit full adder cell shared by both requesters.
module full_adder_v (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_add_sched #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
`ifdef SADD_CIN_EN
    input  logic             req0_cin,
`endif
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
`ifdef SADD_CIN_EN
    input  logic             req1_cin,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id,
    output logic             busy
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic             prio;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             grant_vld;
    logic             grant_id;
    logic             fa_sum;
    logic             fa_cout;

    // Round-robin grant: the preferred requester wins when valid, else the other.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (prio == 1'b0) begin
            if (req0_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end else begin
            if (req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
            end
        end
    end

    // Readys are gated by rst_n so neither requester is accepted during reset.
    assign req0_ready = rst_n && (state == S_IDLE) && grant_vld && !grant_id;
    assign req1_ready = rst_n && (state == S_IDLE) && grant_vld &&  grant_id;

    full_adder_v u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c_in  (carry),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            prio      <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_id    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        a_sh   <= grant_id ? req1_a : req0_a;
                        b_sh   <= grant_id ? req1_b : req0_b;
`ifdef SADD_CIN_EN
                        carry  <= grant_id ? req1_cin : req0_cin;
`else
                        carry  <= 1'b0;
`endif
                        cnt    <= '0;
                        res_id <= grant_id;
                        prio   <= ~grant_id;
                        busy   <= 1'b1;
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                    res_sum <= {fa_sum, res_sum[WIDTH-1:1]};
                    carry   <= fa_cout;
                    a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        res_cout  <= fa_cout;
                        res_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sched.sv
// Testbench for serial_add_sched: directed scenarios with hand-computed results.
`timescale 1ns/1ps

module tb_serial_add_sched;
    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_id;
    logic             busy;

    int  n_cmp;
    int  n_err;
    bit  exp_prio;

    serial_add_sched #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
`ifdef SADD_CIN_EN
        .req0_cin   (req0_cin),
`endif
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
`ifdef SADD_CIN_EN
        .req1_cin   (req1_cin),
`endif
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02;
        req1_valid = 1'b1; req1_a = 8'h03; req1_b = 8'h04;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
                n_err++;
            end
        end
        n_cmp++;
        if ({res_valid, res_sum, res_cout, res_id, busy} !== 12'h000) begin
            $display("FAIL reset_outputs: got v=%b sum=%h c=%b id=%b busy=%b expected all 0",
                     res_valid, res_sum, res_cout, res_id, busy);
            n_err++;
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            $display("FAIL reset_prio: got r0r1=%b expected 10", {req0_ready, req1_ready});
            n_err++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        exp_prio = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_carry_through();
        req0_a = 8'hFF; req0_b = 8'h01; req0_cin = 1'b0; req0_valid = 1'b1;
        res_ready = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            $display("FAIL accept_busy: got %b expected 1", busy);
            n_err++;
        end
        for (int k = 1; k < WIDTH; k++) begin
            @(negedge clk);
            n_cmp++;
            if (res_valid !== 1'b0) begin
                $display("FAIL latency_early: got res_valid=%b at cycle %0d expected 0", res_valid, k);
                n_err++;
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({res_valid, res_sum, res_cout, res_id} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
            $display("FAIL ff_plus_01: got v=%b sum=%h c=%b id=%b expected v=1 sum=00 c=1 id=0",
                     res_valid, res_sum, res_cout, res_id);
            n_err++;
        end
        exp_prio = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        n_cmp++;
        if ({res_valid, busy} !== 2'b00) begin
            $display("FAIL done_release: got v=%b busy=%b expected 00", res_valid, busy);
            n_err++;
        end
    endtask

    task automatic test_alternate();
        int gap;
        bit seen;
        bit exp_id;
        req0_a = 8'h12; req0_b = 8'h34; req0_cin = 1'b0;
        req1_a = 8'h80; req1_b = 8'h80; req1_cin = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        res_ready = 1'b1;
        for (int op = 0; op < 4; op++) begin
            gap = 0;
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                gap++;
                if (res_valid) seen = 1'b1;
            end
            n_cmp++;
            if (!seen) begin
                $display("FAIL alt_timeout: got no res_valid within 20 cycles for op %0d", op);
                n_err++;
            end else begin
                exp_id = exp_prio;
                if (exp_id == 1'b0) begin
                    if ({res_id, res_sum, res_cout} !== {1'b0, 8'h46, 1'b0}) begin
                        $display("FAIL alt_op%0d: got id=%b sum=%h c=%b expected id=0 sum=46 c=0",
                                 op, res_id, res_sum, res_cout);
                        n_err++;
                    end
                end else begin
                    if ({res_id, res_sum, res_cout} !== {1'b1, 8'h00, 1'b1}) begin
                        $display("FAIL alt_op%0d: got id=%b sum=%h c=%b expected id=1 sum=00 c=1",
                                 op, res_id, res_sum, res_cout);
                        n_err++;
                    end
                end
                if (op > 0) begin
                    n_cmp++;
                    if (gap != WIDTH + 2) begin
                        $display("FAIL alt_period: got %0d cycles expected %0d", gap, WIDTH + 2);
                        n_err++;
                    end
                end
                exp_prio = ~exp_id;
            end
            if (op == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        @(negedge clk);
        res_ready = 1'b0;
        n_cmp++;
        if ({res_valid, busy} !== 2'b00) begin
            $display("FAIL alt_idle: got v=%b busy=%b expected 00", res_valid, busy);
            n_err++;
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        req0_a = 8'h0F; req0_b = 8'hF0; req0_cin = 1'b0; req0_valid = 1'b1;
        res_ready = 1'b1 - 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            $display("FAIL bp_timeout: got no res_valid within 20 cycles");
            n_err++;
        end
        exp_prio = 1'b1;
        req1_a = 8'h11; req1_b = 8'h22; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({res_valid, res_sum, res_cout, res_id, busy, req0_ready, req1_ready}
                    !== {1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
                $display("FAIL bp_hold%0d: got v=%b sum=%h c=%b id=%b busy=%b r0=%b r1=%b expected v=1 sum=ff c=0 id=0 busy=1 r0=0 r1=0",
                         i, res_valid, res_sum, res_cout, res_id, busy, req0_ready, req1_ready);
                n_err++;
            end
        end
        req1_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        n_cmp++;
        if ({res_valid, busy} !== 2'b00) begin
            $display("FAIL bp_release: got v=%b busy=%b expected 00", res_valid, busy);
            n_err++;
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        req1_a = 8'h55; req1_b = 8'hAA; req1_cin = 1'b0; req1_valid = 1'b1;
        @(negedge clk);
        req1_valid = 1'b0;
        n_cmp++;
        if ({busy, res_id} !== 2'b11) begin
            $display("FAIL mid_accept: got busy=%b id=%b expected 11", busy, res_id);
            n_err++;
        end
        for (int i = 0; i < 3; i++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if ({res_valid, busy} !== 2'b00) begin
            $display("FAIL mid_abort: got v=%b busy=%b expected 00", res_valid, busy);
            n_err++;
        end
        exp_prio = 1'b0;
        res_ready = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (res_valid) pulses++;
        end
        res_ready = 1'b0;
        n_cmp++;
        if (pulses != 0) begin
            $display("FAIL mid_no_result: got %0d res_valid cycles expected 0", pulses);
            n_err++;
        end
    endtask

    task automatic test_cin();
        bit seen;
        logic [WIDTH-1:0] exp_sum;
`ifdef SADD_CIN_EN
        exp_sum = 8'h80;
`else
        exp_sum = 8'h7F;
`endif
        req0_a = 8'h7F; req0_b = 8'h00; req0_cin = 1'b1; req0_valid = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            $display("FAIL cin_timeout: got no res_valid within 20 cycles");
            n_err++;
        end else if ({res_sum, res_cout, res_id} !== {exp_sum, 1'b0, 1'b0}) begin
            $display("FAIL cin_sum: got sum=%h c=%b id=%b expected sum=%h c=0 id=0",
                     res_sum, res_cout, res_id, exp_sum);
            n_err++;
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_prio = 1'b0;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        res_ready = 1'b0;
        test_reset();
        test_carry_through();
        test_alternate();
        test_backpressure();
        test_reset_mid();
        test_cin();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
